// File: rtl/pte_fetch_bridge_if.sv
// MMU fetch port and Wishbone read-bus signals of the page-table fetch bridge.
// The slave modport is the bridge's view; master is the MMU/bus environment's view.
interface pte_fetch_bridge_if;
    logic        ren;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] data;
    logic        flush;
    logic        busy;
    logic        wb_cyc;
    logic        wb_stb;
    logic [29:0] wb_adr;
    logic        wb_ack;
    logic        wb_err;
    logic [31:0] wb_dat_i;

    modport slave (
        input  ren, addr, flush, wb_ack, wb_err, wb_dat_i,
        output ack, data, busy, wb_cyc, wb_stb, wb_adr
    );

    modport master (
        output ren, addr, flush, wb_ack, wb_err, wb_dat_i,
        input  ack, data, busy, wb_cyc, wb_stb, wb_adr
    );
endinterface

// File: rtl/pte_fetch_bridge.sv
// Page-table word fetch bridge: small fully-associative buffer answering MMU fetches,
// with single classic Wishbone reads on a miss. All outputs are registered.
module pte_fetch_bridge #(
    parameter int NENT    = 4,
    parameter int TIMEOUT = 255
) (
    input logic              clk,
    input logic              rst,
    pte_fetch_bridge_if.slave bus
);
    localparam int PW = $clog2(NENT);

    typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

    state_t          state, state_n;
    logic [29:0]     tag_q  [NENT];
    logic [31:0]     word_q [NENT];
    logic [NENT-1:0] valid;
    logic [PW-1:0]   ptr;
    logic [7:0]      cnt;
    logic            flush_seen;
    logic            ack, busy, wb_cyc;
    logic [31:0]     data;
    logic [29:0]     wb_adr;
    logic [29:0]     lookup_tag;
    logic            hit, fill, abort;
    logic [31:0]     hit_word;

    assign lookup_tag = bus.addr[31:2];

    // Lowest-index match wins; wb_err beats wb_ack; a flush seen during the bus read suppresses the fill.
    always_comb begin
        state_n  = state;
        hit      = 1'b0;
        hit_word = '0;
        fill     = 1'b0;
        abort    = 1'b0;
        for (int i = 0; i < NENT; i++) begin
            if (!hit && valid[i] && tag_q[i] == lookup_tag) begin
                hit      = 1'b1;
                hit_word = word_q[i];
            end
        end
        case (state)
            IDLE: begin
                if (bus.ren) state_n = (hit && !bus.flush) ? RESP : BUS;
            end
            BUS: begin
                if (bus.wb_err || (!bus.wb_ack && cnt == 8'(TIMEOUT - 1))) begin
                    abort   = 1'b1;
                    state_n = RESP;
                end else if (bus.wb_ack) begin
                    fill    = !(bus.flush || flush_seen);
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // wb_adr doubles as the latched request tag used for the fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ack        <= 1'b0;
            busy       <= 1'b0;
            wb_cyc     <= 1'b0;
            wb_adr     <= '0;
            data       <= '0;
            cnt        <= '0;
            flush_seen <= 1'b0;
            valid      <= '0;
            ptr        <= '0;
        end else begin
            ack        <= (state_n == RESP);
            busy       <= (state_n != IDLE);
            wb_cyc     <= (state_n == BUS);
            cnt        <= (state == BUS && state_n == BUS) ? cnt + 8'd1 : 8'd0;
            flush_seen <= (state == BUS && state_n == BUS) && (flush_seen || bus.flush);
            if (state == IDLE && state_n == BUS)
                wb_adr <= lookup_tag;
            if (state == IDLE && state_n == RESP)
                data <= hit_word;
            else if (state == BUS && state_n == RESP)
                data <= abort ? 32'h0 : bus.wb_dat_i;
            if (bus.flush) begin
                valid <= '0;
                ptr   <= '0;
            end else if (fill) begin
                valid[ptr] <= 1'b1;
                ptr        <= ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            tag_q[ptr]  <= wb_adr;
            word_q[ptr] <= bus.wb_dat_i;
        end
    end

    assign bus.ack    = ack;
    assign bus.data   = data;
    assign bus.busy   = busy;
    assign bus.wb_cyc = wb_cyc;
    assign bus.wb_stb = wb_cyc;
    assign bus.wb_adr = wb_adr;
endmodule

// File: tb/tb_pte_fetch_bridge.sv
// Self-checking bench for pte_fetch_bridge: directed and random fetches checked
// against a FIFO-replacement buffer model.
module tb_pte_fetch_bridge;
    localparam int NENT = 4;

    typedef struct {
        logic [29:0] tag;
        logic [31:0] word;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    ent_t model_q[$];
    logic [31:0] pool [6];

    pte_fetch_bridge_if bus_if ();

    pte_fetch_bridge #(.NENT(NENT), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_lookup(input logic [29:0] t, output bit hit, output logic [31:0] w);
        hit = 0;
        w   = '0;
        foreach (model_q[i]) if (model_q[i].tag == t) begin hit = 1; w = model_q[i].word; end
    endtask

    // The oldest fill is the one replaced once the buffer is full.
    task automatic model_fill(input logic [29:0] t, input logic [31:0] w);
        ent_t e;
        e.tag  = t;
        e.word = w;
        model_q.push_back(e);
        if (model_q.size() > NENT) void'(model_q.pop_front());
    endtask

    task automatic idle_flush();
        bus_if.flush = 1'b1;
        @(posedge clk); #1;
        bus_if.flush = 1'b0;
        model_q.delete();
    endtask

    // kind: 0 = wb_ack, 1 = wb_err, 2 = no response, 3 = wb_ack and wb_err together
    task automatic fetch(input logic [31:0] a, input int kind, input int k, input logic [31:0] dat,
                         input bit flush_bus, input bit drop_ren, input bit flush_ren);
        logic [29:0] t;
        bit          hit;
        logic [31:0] hw;
        int          n;
        t = a[31:2];
        model_lookup(t, hit, hw);
        if (flush_ren) begin
            hit = 0;
            model_q.delete();
        end
        bus_if.ren   = 1'b1;
        bus_if.addr  = a;
        bus_if.flush = flush_ren;
        @(posedge clk); #1;
        bus_if.flush = 1'b0;
        if (hit) begin
            check("hit_ack", bus_if.ack, 1);
            check("hit_data", bus_if.data, hw);
            check("hit_no_cyc", bus_if.wb_cyc, 0);
        end else begin
            check("miss_cyc_stb", {bus_if.wb_cyc, bus_if.wb_stb}, 2'b11);
            check("miss_adr", bus_if.wb_adr, t);
            check("miss_no_ack", bus_if.ack, 0);
            check("miss_busy", bus_if.busy, 1);
            if (drop_ren) bus_if.ren = 1'b0;
            if (flush_bus) begin
                bus_if.flush = 1'b1;
                model_q.delete();
            end
            if (kind == 2) begin
                n = 1;
                for (int i = 0; i < 300; i++) begin
                    @(posedge clk); #1;
                    bus_if.flush = 1'b0;
                    if (bus_if.wb_cyc) n++;
                    else break;
                end
                check("timeout_cycles", n, 255);
                check("timeout_ack", bus_if.ack, 1);
                check("timeout_data", bus_if.data, 0);
            end else begin
                for (int i = 1; i < k; i++) begin
                    @(posedge clk); #1;
                    bus_if.flush = 1'b0;
                    check("bus_hold_adr", bus_if.wb_adr, t);
                end
                bus_if.wb_ack   = (kind == 0 || kind == 3);
                bus_if.wb_err   = (kind == 1 || kind == 3);
                bus_if.wb_dat_i = dat;
                @(posedge clk); #1;
                bus_if.flush  = 1'b0;
                bus_if.wb_ack = 1'b0;
                bus_if.wb_err = 1'b0;
                check("resp_ack", bus_if.ack, 1);
                check("resp_data", bus_if.data, (kind == 0) ? dat : 32'h0);
                check("resp_cyc_low", bus_if.wb_cyc, 0);
                if (kind == 0 && !flush_bus) model_fill(t, dat);
            end
        end
        bus_if.ren = 1'b0;
        @(posedge clk); #1;
        check("after_ack_low", bus_if.ack, 0);
        check("after_busy_low", bus_if.busy, 0);
    endtask

    initial begin
        bus_if.ren      = 1'b0;
        bus_if.addr     = '0;
        bus_if.flush    = 1'b0;
        bus_if.wb_ack   = 1'b0;
        bus_if.wb_err   = 1'b0;
        bus_if.wb_dat_i = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_ack", bus_if.ack, 0);
        check("reset_data", bus_if.data, 0);
        check("reset_busy", bus_if.busy, 0);
        check("reset_cyc", bus_if.wb_cyc, 0);
        check("reset_stb", bus_if.wb_stb, 0);
        check("reset_adr", bus_if.wb_adr, 0);
        rst = 1'b1;
        @(posedge clk); #1;

        fetch(32'h0001_2344, 0, 3, 32'hABCD_E007, 0, 0, 0);
        check("cold_adr_const", 32'(32'h0001_2344 >> 2), 32'h0000_48D1);
        fetch(32'h0001_2344, 0, 1, 32'h0, 0, 0, 0);
        fetch(32'h0001_2347, 0, 1, 32'h0, 0, 0, 0);

        idle_flush();
        for (int i = 0; i < 5; i++)
            fetch(32'h0010_0000 + 32'(i * 16), 0, 2, 32'h5000_0001 + 32'(i), 0, 0, 0);
        fetch(32'h0010_0010, 0, 1, 32'h0, 0, 0, 0);
        fetch(32'h0010_0000, 0, 2, 32'h6000_0003, 0, 0, 0);

        fetch(32'h0020_0040, 1, 2, 32'hDEAD_BEEF, 0, 0, 0);
        fetch(32'h0020_0040, 0, 1, 32'h7000_0007, 0, 0, 0);
        fetch(32'h0020_0080, 2, 1, 32'h0, 0, 0, 0);
        fetch(32'h0020_00C0, 3, 2, 32'h1234_5677, 0, 0, 0);

        fetch(32'h0001_2344, 0, 1, 32'hABCD_E007, 0, 0, 0);
        idle_flush();
        fetch(32'h0001_2344, 0, 2, 32'hABCD_E007, 0, 0, 0);

        fetch(32'h0030_0100, 0, 3, 32'h8888_0001, 1, 0, 0);
        fetch(32'h0030_0100, 0, 1, 32'h8888_0003, 0, 0, 0);
        fetch(32'h0030_0100, 0, 1, 32'h0, 0, 0, 0);

        fetch(32'h0040_0200, 0, 2, 32'h9999_0005, 0, 1, 0);
        fetch(32'h0040_0200, 0, 1, 32'h0, 0, 0, 0);
        fetch(32'h0040_0200, 0, 2, 32'hAAAA_0007, 0, 0, 1);
        fetch(32'h0040_0200, 0, 1, 32'h0, 0, 0, 0);

        for (int i = 0; i < 6; i++)
            pool[i] = ($urandom & 32'hFFFF_FF00) | 32'(i << 4);
        for (int n = 0; n < 40; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            fetch(pool[$urandom_range(0, 5)] | 32'($urandom_range(0, 3)),
                  (r < 7) ? 0 : ((r < 9) ? 1 : 3),
                  int'($urandom_range(1, 4)), $urandom,
                  ($urandom_range(0, 7) == 0), 0, 0);
        end

        fetch(32'h0050_0300, 0, 1, 32'hBBBB_0009, 0, 0, 0);
        fetch(32'h0050_0300, 0, 1, 32'h0, 0, 0, 0);
        bus_if.ren  = 1'b1;
        bus_if.addr = 32'h0060_0400;
        @(posedge clk); #1;
        check("areset_pre_cyc", bus_if.wb_cyc, 1);
        #2;
        rst = 1'b0;
        #1;
        check("areset_cyc", bus_if.wb_cyc, 0);
        check("areset_ack", bus_if.ack, 0);
        check("areset_busy", bus_if.busy, 0);
        check("areset_data", bus_if.data, 0);
        bus_if.ren = 1'b0;
        model_q.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        fetch(32'h0050_0300, 0, 2, 32'hCCCC_000B, 0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end
endmodule
